// File: rtl/mem_io_pkg.sv
// ============================================================================
// Module   : mem_io_pkg
// Purpose  : Shared types and constants for the memory/MMIO responder.
//            Holds the responder state encoding, the default memory-mapped
//            switch/hex address and the wait-state counter width.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_io_pkg;

    // Wait-state down-counter width; WAIT_CYCLES must fit (1..15).
    localparam int CNT_W = 4;

    // Address decoded as the switch (read) / hex display (write) register.
    localparam logic [15:0] MMIO_ADDR_DEFAULT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MMIO      = 2'd1,
        SRAM_WAIT = 2'd2,
        DONE      = 2'd3
    } state_t;

    // True when an address targets the memory-mapped register.
    function automatic logic is_mmio(input logic [15:0] addr,
                                     input logic [15:0] mmio_addr);
        return (addr == mmio_addr);
    endfunction

endpackage

`default_nettype wire

// File: rtl/register.sv
// ============================================================================
// Module   : register
// Purpose  : Generic N-bit load-enabled holding register.
// Ports    : Clk    - clock
//            Reset  - synchronous active-high reset, clears D_Out
//            Load   - when high, D_In is captured on the rising edge
//            D_In   - data to capture
//            D_Out  - registered value
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module register #(
    parameter int N = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Load,
    input  logic [N-1:0] D_In,
    output logic [N-1:0] D_Out
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            D_Out <= '0;
        end else if (Load) begin
            D_Out <= D_In;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_io_responder.sv
// ============================================================================
// Module   : mem_io_responder
// Purpose  : Services single CPU memory requests. The MMIO address reads the
//            switches / writes the hex display register; every other address
//            is forwarded to an SRAM with a fixed number of wait states.
//            Completion is signalled by a one-cycle R pulse.
// Ports    : Clk, Reset          - clock, synchronous active-high reset
//            MEM_EN, WE          - request valid, 1=write / 0=read
//            ADDR, WDATA         - request address and write data
//            R                   - access-complete pulse
//            MDR_In              - read data returned to the CPU
//            SW, HEX             - switches in, hex display register out
//            sram_ce, sram_we    - SRAM strobes (only active in SRAM_WAIT)
//            sram_addr/wdata     - SRAM address and write data
//            sram_rdata          - SRAM read data, valid on last wait cycle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] MMIO_ADDR   = MMIO_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MEM_EN,
    input  logic        WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] WDATA,
    output logic        R,
    output logic [15:0] MDR_In,
    input  logic [9:0]  SW,
    output logic [15:0] HEX,
    output logic        sram_ce,
    output logic        sram_we,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t           state;
    logic             armed;
    logic             we_q;
    logic [15:0]      wdata_q;
    logic [CNT_W-1:0] cnt;
    logic             hex_load;

    // HEX captures the latched write data on the edge leaving MMIO, so a
    // reset during MMIO wins over the load inside the register.
    assign hex_load = (state == MMIO) && we_q;

    register #(
        .N (16)
    ) u_hex_reg (
        .Clk   (Clk),
        .Reset (Reset),
        .Load  (hex_load),
        .D_In  (wdata_q),
        .D_Out (HEX)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            armed      <= 1'b1;
            R          <= 1'b0;
            MDR_In     <= '0;
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            cnt        <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
        end else begin
            R <= 1'b0;

            // A request held high is serviced once; dropping MEM_EN for at
            // least one cycle re-arms the responder.
            if (!MEM_EN) begin
                armed <= 1'b1;
            end else if (R) begin
                armed <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (MEM_EN && armed) begin
                        we_q    <= WE;
                        wdata_q <= WDATA;
                        if (is_mmio(ADDR, MMIO_ADDR)) begin
                            state <= MMIO;
                        end else begin
                            // SRAM strobes are registered so they are valid
                            // for the whole of every SRAM_WAIT cycle.
                            state      <= SRAM_WAIT;
                            cnt        <= WAIT_LOAD;
                            sram_ce    <= 1'b1;
                            sram_we    <= WE;
                            sram_addr  <= ADDR;
                            sram_wdata <= WDATA;
                        end
                    end
                end

                MMIO: begin
                    if (!we_q) begin
                        MDR_In <= {6'b0, SW};
                    end
                    state <= DONE;
                    R     <= 1'b1;
                end

                SRAM_WAIT: begin
                    if (cnt <= CNT_W'(1)) begin
                        // Last wait cycle: the SRAM data is valid now.
                        if (!we_q) begin
                            MDR_In <= sram_rdata;
                        end
                        sram_ce <= 1'b0;
                        sram_we <= 1'b0;
                        cnt     <= '0;
                        state   <= DONE;
                        R       <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_io_responder.sv
// ============================================================================
// Module   : tb_mem_io_responder
// Purpose  : Scoreboard bench for mem_io_responder. Stimulus pushes expected
//            completions into a queue; a negedge monitor pops and compares
//            on every R pulse and checks SRAM strobes while sram_ce is high.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_io_responder;

    typedef struct {
        int          acc;    // cycle index of the accepting edge
        int          lat;    // expected accept-to-R latency
        logic [15:0] mdr;
        logic [15:0] hex;
        int          ce_cycles;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MEM_EN = 1'b0;
    logic        WE = 1'b0;
    logic [15:0] ADDR = '0;
    logic [15:0] WDATA = '0;
    logic        R;
    logic [15:0] MDR_In;
    logic [9:0]  SW = '0;
    logic [15:0] HEX;
    logic        sram_ce;
    logic        sram_we;
    logic [15:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata = '0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ce_cnt = 0;
    int   r_pulses = 0;
    exp_t exp_q[$];

    mem_io_responder #(
        .WAIT_CYCLES (2),
        .MMIO_ADDR   (16'hFFFF)
    ) dut (
        .Clk        (clk),
        .Reset      (rst),
        .MEM_EN     (MEM_EN),
        .WE         (WE),
        .ADDR       (ADDR),
        .WDATA      (WDATA),
        .R          (R),
        .MDR_In     (MDR_In),
        .SW         (SW),
        .HEX        (HEX),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: strobe checks while the SRAM is selected, scoreboard on R.
    always @(negedge clk) begin
        if (!rst) begin
            if (sram_ce) begin
                ce_cnt++;
                if (exp_q.size() > 0) begin
                    check("sram_we", {31'b0, sram_we}, {31'b0, exp_q[0].we});
                    check("sram_addr", {16'b0, sram_addr}, {16'b0, exp_q[0].addr});
                    check("sram_wdata", {16'b0, sram_wdata}, {16'b0, exp_q[0].wdata});
                end
            end
            if (R) begin
                r_pulses++;
                if (exp_q.size() == 0) begin
                    check("unexpected_R", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    check("MDR_In", {16'b0, MDR_In}, {16'b0, e.mdr});
                    check("HEX", {16'b0, HEX}, {16'b0, e.hex});
                    check("ce_cycles", 32'(ce_cnt), 32'(e.ce_cycles));
                end
                ce_cnt = 0;
            end
        end
    end

    // Issue one request (already at a negedge), push its expectation at the
    // accepting edge and wait for R with a bounded loop.
    task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                             input int lat, input logic [15:0] mdr, input logic [15:0] hex,
                             input int ce_cycles, input logic drop_early);
        exp_t e;
        logic got;
        MEM_EN = 1'b1;
        WE     = we;
        ADDR   = addr;
        WDATA  = wd;
        @(posedge clk);
        #1;
        e.acc = cyc; e.lat = lat; e.mdr = mdr; e.hex = hex;
        e.ce_cycles = ce_cycles; e.we = we; e.addr = addr; e.wdata = wd;
        exp_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (drop_early && i == 0) MEM_EN = 1'b0;
            if (R) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("R_timeout", 32'd0, 32'd1);
        MEM_EN = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int rp0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_R", {31'b0, R}, 32'd0);
        check("reset_MDR", {16'b0, MDR_In}, 32'd0);
        check("reset_HEX", {16'b0, HEX}, 32'd0);
        check("reset_ce_we", {30'b0, sram_ce, sram_we}, 32'd0);
        check("reset_addr_data", {sram_addr, sram_wdata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // SRAM read, 2 wait states, R 3 cycles after accept.
        sram_rdata = 16'hBEEF;
        do_access(1'b0, 16'h3000, 16'h0000, 3, 16'hBEEF, 16'h0000, 2, 1'b0);
        // SRAM write; MEM_EN dropped mid-access, MDR_In unchanged.
        do_access(1'b1, 16'h0042, 16'h1234, 3, 16'hBEEF, 16'h0000, 2, 1'b1);
        // MMIO read of the switches.
        SW = 10'h2A5;
        do_access(1'b0, 16'hFFFF, 16'h0000, 2, 16'h02A5, 16'h0000, 0, 1'b0);
        // MMIO write to the hex register.
        do_access(1'b1, 16'hFFFF, 16'hCAFE, 2, 16'h02A5, 16'hCAFE, 0, 1'b0);

        // MEM_EN held high for 10 cycles: exactly one completion.
        sram_rdata = 16'h5A5A;
        rp0 = r_pulses;
        MEM_EN = 1'b1; WE = 1'b0; ADDR = 16'h0100; WDATA = 16'h0000;
        @(posedge clk);
        #1;
        exp_q.push_back('{acc: cyc, lat: 3, mdr: 16'h5A5A, hex: 16'hCAFE,
                          ce_cycles: 2, we: 1'b0, addr: 16'h0100, wdata: 16'h0000});
        repeat (10) @(negedge clk);
        check("held_single_R", 32'(r_pulses - rp0), 32'd1);
        MEM_EN = 1'b0;
        @(negedge clk);
        sram_rdata = 16'h1357;
        do_access(1'b0, 16'h0200, 16'h0000, 3, 16'h1357, 16'hCAFE, 2, 1'b0);

        // Reset during the 2nd SRAM_WAIT cycle aborts the access.
        rp0 = r_pulses;
        MEM_EN = 1'b1; WE = 1'b0; ADDR = 16'h3000; WDATA = 16'h0000;
        sram_rdata = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        MEM_EN = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", {R, sram_ce, sram_we, 13'b0, MDR_In}, 32'd0);
        check("abort_HEX", {16'b0, HEX}, 32'd0);
        check("abort_sram_bus", {sram_addr, sram_wdata}, 32'd0);
        rst = 1'b0;
        ce_cnt = 0;
        repeat (4) @(negedge clk);
        check("abort_no_R", 32'(r_pulses - rp0), 32'd0);
        do_access(1'b0, 16'h3000, 16'h0000, 3, 16'hBEEF, 16'h0000, 2, 1'b0);
        do_access(1'b0, 16'hFFFF, 16'h0000, 2, 16'h02A5, 16'h0000, 0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, which sets the SRAM access wait states (legal range 1..15).
REQ-002 The block SHALL have parameter MMIO_ADDR, default 16'hFFFF, which is the memory-mapped switch/hex address.
REQ-003 The block SHALL have one clock (Clk) and a synchronous, active-high reset (Reset), exactly as already decided.
REQ-004 The block SHALL have these ports:
- Clk  in  1  clock
- Reset  in  1  sync active-high reset
- MEM_EN  in  1  CPU request valid
- WE  in  1  1=write, 0=read
- ADDR  in  16  CPU MAR
- WDATA  in  16  CPU MDR
- R  out  1  access-complete pulse
- MDR_In  out  16  read data returned to CPU
- SW  in  10  switches
- HEX  out  16  hex-display register
- sram_ce  out  1  SRAM chip enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  16  SRAM address
- sram_wdata  out  16  SRAM write data
- sram_rdata  in  16  SRAM read data, valid on the last wait cycle

Function
REQ-005 The FSM SHALL have the states IDLE, MMIO, SRAM_WAIT and DONE.
REQ-006 In IDLE with MEM_EN=1 and armed=1, the block SHALL latch ADDR, WDATA and WE, then go to MMIO if ADDR==MMIO_ADDR, else to SRAM_WAIT.
REQ-007 The armed flag SHALL clear when R asserts and SHALL set on any cycle with MEM_EN=0, so that a request held high is serviced exactly once.
REQ-008 In MMIO, a read SHALL load MDR_In={6'b0,SW} sampled that cycle, a write SHALL load HEX with the latched WDATA, and no SRAM signal SHALL be asserted; the next state SHALL be DONE.
REQ-009 In SRAM_WAIT, sram_ce SHALL be 1, sram_we SHALL equal the latched WE, and sram_addr/sram_wdata SHALL be held stable for exactly WAIT_CYCLES cycles, counted by a down-counter.
REQ-010 On the final wait cycle of a read, MDR_In SHALL capture sram_rdata; the next state SHALL then be DONE.
REQ-011 In DONE, R SHALL be 1 for exactly one cycle and the next state SHALL be IDLE.
REQ-012 Latency from the accepting edge to R high SHALL be 2 cycles for MMIO and WAIT_CYCLES+1 cycles for SRAM.
REQ-013 MDR_In SHALL hold its value until the next read completes, and writes SHALL NOT change MDR_In.
REQ-014 If MEM_EN drops mid-access, the access SHALL still complete and R SHALL still pulse.
REQ-015 Requests SHALL NOT be accepted outside IDLE and SHALL NOT be queued.
REQ-016 Outside SRAM_WAIT, sram_ce and sram_we SHALL be 0.
REQ-017 HEX SHALL change only on MMIO writes.

Reset
REQ-018 On Reset, the state SHALL be IDLE, armed=1, and R, MDR_In, HEX, sram_ce, sram_we, sram_addr, sram_wdata and the counter SHALL all be 0.
REQ-019 Reset mid-access SHALL abort the access with no R pulse and no HEX update.

Structure
REQ-020 Package mem_io_pkg SHALL hold the state enum, the MMIO_ADDR default and the counter width (4 bits).
REQ-021 The HEX holding register SHALL be an instance of the existing generic register module (N=16).

Verification
REQ-022 The bench SHALL cover these scenarios:
- Read 0x3000 with SRAM returning 0xBEEF, WAIT_CYCLES=2 -> sram_ce high 2 cycles, R pulses 3 cycles after accept, MDR_In=0xBEEF.
- Write 0x1234 to 0x0042 -> sram_we=1 for 2 cycles with addr 0x0042 and data 0x1234; MDR_In unchanged.
- SW=10'h2A5, read 0xFFFF -> R 2 cycles after accept, MDR_In=0x02A5, sram_ce never high.
- Write 0xCAFE to 0xFFFF -> HEX=0xCAFE, no SRAM activity.
- MEM_EN held high 10 cycles -> exactly one R pulse; after MEM_EN low 1 cycle then high -> a second access.
- Reset asserted in the 2nd SRAM_WAIT cycle -> no R, all outputs 0, next request serviced normally.
